// File: rtl/dl_frame_rx.sv
// dl_frame_rx - downlink frame receiver for the MAC scheduler.
//
// Hunts the demodulated bitstream for PREAMBLE (MSB first), then reads a
// 2-bit category and its payload (01: 8-bit beacon flags, 10: 48-bit slot
// scheme, 11: heartbeat with no payload). An accepted frame publishes ctg,
// the payload field and an LFSR snapshot, and bumps the 2-bit ord counter.
// All published outputs change on the same edge so the MAC sees them
// atomically.
//
// Build option: define DL_FRAME_CRC_EN to append and check a CRC-8
// (poly 0x07, init 0x00) over the ctg and payload bits.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-low reset
//   bit_valid  in   one-cycle strobe qualifying bit_in
//   bit_in     in   demodulated downlink bit
//   ord        out  frame sequence counter, +1 mod 4 per accepted frame
//   ctg        out  category of the last accepted frame
//   cur_flag   out  beacon slot-occupancy flags
//   cur_scheme out  eight 6-bit slot lengths
//   cur_rand   out  LFSR snapshot taken at frame accept
//   frame_ok   out  one-cycle pulse on accept
//   frame_err  out  one-cycle pulse on reject (bad ctg, bad CRC, timeout)

module dl_frame_rx #(
    parameter logic [7:0]  PREAMBLE  = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd5000,
    parameter logic [23:0] RAND_SEED = 24'h5EED01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic [1:0]  ord,
    output logic [1:0]  ctg,
    output logic [7:0]  cur_flag,
    output logic [47:0] cur_scheme,
    output logic [23:0] cur_rand,
    output logic        frame_ok,
    output logic        frame_err
);

    // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
    localparam logic [23:0] SEED      = (RAND_SEED == 24'd0) ? 24'h000001 : RAND_SEED;
    localparam logic [23:0] LFSR_MASK = 24'hE10000;

`ifdef DL_FRAME_CRC_EN
    typedef enum logic [1:0] {HUNT, HDR, PAY, CHK} state_t;
`else
    typedef enum logic [1:0] {HUNT, HDR, PAY} state_t;
`endif

    function automatic logic [23:0] lfsr_step(input logic [23:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 24'd0);
    endfunction

`ifdef DL_FRAME_CRC_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    state_t       state;
    // Only the 7 newest bits are kept: the preamble compare always includes
    // the bit being shifted in on this strobe.
    logic [6:0]   window;
    logic [5:0]   cnt;
    logic [1:0]   hdr;
    logic [47:0]  stage;
    logic [15:0]  idle;
    logic [23:0]  lfsr;
`ifdef DL_FRAME_CRC_EN
    logic [7:0]   crc;
    logic [6:0]   crc_rx;
    logic [7:0]   crc_next;
`endif

    logic [1:0]   hdr_next;
    logic [47:0]  pay_next;
    logic         pay_last;
    logic         timed_out;
    logic         accept;
    logic         reject;
    logic [1:0]   acc_ctg;
    logic [47:0]  acc_pay;

    // Accept/reject decision for the current cycle; applied on the edge
    // that samples the frame's final strobe.
    always_comb begin
        hdr_next  = {hdr[0], bit_in};
        pay_next  = {stage[46:0], bit_in};
        pay_last  = (hdr == 2'b01) ? (cnt == 6'd7) : (cnt == 6'd47);
`ifdef DL_FRAME_CRC_EN
        crc_next  = crc8_step(crc, bit_in);
`endif
        // A strobe in the same cycle as the limit wins over the timeout.
        timed_out = (state != HUNT) && !bit_valid && (idle == TIMEOUT - 16'd1);
        accept    = 1'b0;
        reject    = timed_out;
        acc_ctg   = hdr;
        acc_pay   = stage;
        if (bit_valid) begin
            case (state)
                HDR: begin
                    if (cnt[0]) begin
                        acc_ctg = hdr_next;
                        if (hdr_next == 2'b00) begin
                            reject = 1'b1;
                        end
`ifndef DL_FRAME_CRC_EN
                        else if (hdr_next == 2'b11) begin
                            accept = 1'b1;
                        end
`endif
                    end
                end
`ifdef DL_FRAME_CRC_EN
                CHK: begin
                    if (cnt == 6'd7) begin
                        if ({crc_rx, bit_in} == crc) accept = 1'b1;
                        else                         reject = 1'b1;
                    end
                end
`else
                PAY: begin
                    if (pay_last) begin
                        acc_pay = pay_next;
                        accept  = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= HUNT;
            window     <= '0;
            cnt        <= '0;
            idle       <= '0;
            lfsr       <= SEED;
            ord        <= '0;
            ctg        <= '0;
            cur_flag   <= '0;
            cur_scheme <= '0;
            cur_rand   <= SEED;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            lfsr      <= lfsr_step(lfsr);
            frame_ok  <= accept;
            frame_err <= reject;

            if (accept) begin
                ord      <= ord + 2'd1;
                ctg      <= acc_ctg;
                cur_rand <= lfsr;
                if (acc_ctg == 2'b01) cur_flag   <= acc_pay[7:0];
                if (acc_ctg == 2'b10) cur_scheme <= acc_pay;
            end

            if (accept || reject) begin
                state  <= HUNT;
                window <= '0;
            end else begin
                if (state != HUNT) begin
                    idle <= bit_valid ? 16'd0 : idle + 16'd1;
                end
                if (bit_valid) begin
                    case (state)
                        HUNT: begin
                            window <= {window[5:0], bit_in};
                            if ({window, bit_in} == PREAMBLE) begin
                                state <= HDR;
                                cnt   <= '0;
                                idle  <= '0;
`ifdef DL_FRAME_CRC_EN
                                crc   <= '0;
`endif
                            end
                        end
                        HDR: begin
                            hdr <= hdr_next;
                            cnt <= cnt + 6'd1;
`ifdef DL_FRAME_CRC_EN
                            crc <= crc_next;
`endif
                            if (cnt[0]) begin
                                cnt <= '0;
`ifdef DL_FRAME_CRC_EN
                                state <= (hdr_next == 2'b11) ? CHK : PAY;
`else
                                state <= PAY;
`endif
                            end
                        end
                        PAY: begin
                            stage <= pay_next;
                            cnt   <= cnt + 6'd1;
`ifdef DL_FRAME_CRC_EN
                            crc   <= crc_next;
                            if (pay_last) begin
                                cnt   <= '0;
                                state <= CHK;
                            end
`endif
                        end
`ifdef DL_FRAME_CRC_EN
                        CHK: begin
                            crc_rx <= {crc_rx[5:0], bit_in};
                            cnt    <= cnt + 6'd1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dl_frame_rx.sv
// Scoreboard bench for dl_frame_rx: stimulus pushes the expected result of
// each frame, a negedge monitor pops on every frame_ok/frame_err and checks
// held outputs on every other cycle.

module tb_dl_frame_rx;

    localparam logic [7:0]  PRE  = 8'hA5;
    localparam int          TO   = 5000;
    localparam logic [23:0] SEED = 24'h5EED01;
`ifdef DL_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic [1:0]  ord;
    logic [1:0]  ctg;
    logic [7:0]  cur_flag;
    logic [47:0] cur_scheme;
    logic [23:0] cur_rand;
    logic        frame_ok;
    logic        frame_err;

    always #5 clock = ~clock;

    dl_frame_rx dut (
        .clock      (clock),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .ord        (ord),
        .ctg        (ctg),
        .cur_flag   (cur_flag),
        .cur_scheme (cur_scheme),
        .cur_rand   (cur_rand),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err)
    );

    typedef struct {
        bit          ok;
        logic [1:0]  ord;
        logic [1:0]  ctg;
        logic [7:0]  flag;
        logic [47:0] scheme;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state of what the receiver should have published.
    logic [1:0]  m_ord = 2'd0;
    logic [1:0]  m_ctg = 2'd0;
    logic [7:0]  m_flag = 8'd0;
    logic [47:0] m_scheme = 48'd0;

    function void check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Galois right-shift LFSR, mask E10000, reset to the seed.
    function automatic logic [23:0] lf_step(input logic [23:0] v);
        return (v >> 1) ^ (v[0] ? 24'hE10000 : 24'd0);
    endfunction

    logic [23:0] lf = 24'd0;
    logic [23:0] lf_prev = 24'd0;
    bit          rst_at_edge = 1'b1;

    always @(posedge clock) begin
        lf_prev     = lf;
        rst_at_edge = !reset;
        lf          = reset ? lf_step(lf) : SEED;
    end

    // Monitor
    logic [1:0]  pub_ord = 2'd0;
    logic [1:0]  pub_ctg = 2'd0;
    logic [7:0]  pub_flag = 8'd0;
    logic [47:0] pub_scheme = 48'd0;
    logic [23:0] pub_rand = SEED;
    exp_t        e;

    always @(negedge clock) begin
        if (rst_at_edge) begin
            pub_ord = 2'd0; pub_ctg = 2'd0; pub_flag = 8'd0;
            pub_scheme = 48'd0; pub_rand = SEED;
            check("reset_outputs", {ord, ctg, cur_flag, cur_scheme, cur_rand, frame_ok, frame_err},
                  {2'd0, 2'd0, 8'd0, 48'd0, SEED, 2'b00});
        end else if (frame_ok || frame_err) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual ok=%0b err=%0b required=no pulse", frame_ok, frame_err);
            end else begin
                e = sbq.pop_front();
                check("pulse_kind", {frame_ok, frame_err}, e.ok ? 2'b10 : 2'b01);
                check("ord", ord, e.ord);
                check("ctg", ctg, e.ctg);
                check("cur_flag", cur_flag, e.flag);
                check("cur_scheme", cur_scheme, e.scheme);
                check("cur_rand", cur_rand, e.ok ? lf_prev : pub_rand);
                if (e.ok) pub_rand = lf_prev;
                pub_ord = e.ord; pub_ctg = e.ctg; pub_flag = e.flag; pub_scheme = e.scheme;
            end
        end else begin
            check("hold", {ord, ctg, cur_flag, cur_scheme, cur_rand},
                  {pub_ord, pub_ctg, pub_flag, pub_scheme, pub_rand});
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push_exp(input bit ok);
        sbq.push_back('{ok, m_ord, m_ctg, m_flag, m_scheme});
    endtask

    task automatic drive_bits(input bit bits[$], input int gmax, input bit idle_end);
        int g;
        foreach (bits[i]) begin
            bit_valid = 1'b1;
            bit_in    = bits[i];
            tick();
            g = (gmax > 0) ? int'($urandom_range(gmax)) : 0;
            if (g > 0 && i != bits.size() - 1) begin
                bit_valid = 1'b0;
                repeat (g) tick();
            end
        end
        if (idle_end) bit_valid = 1'b0;
    endtask

    // Build a frame, record its expected outcome, then send it.
    task automatic send_frame(input logic [1:0] c, input logic [47:0] p, input bit bad_crc,
                              input int gmax, input bit idle_end);
        bit       bits[$];
        bit       body[$];
        int       plen;
        logic [7:0] crc;
        bit       fb;
        bit       bad;
        plen = (c == 2'b01) ? 8 : (c == 2'b10) ? 48 : 0;
        bad  = bad_crc && CRC_ON;
        for (int i = 7; i >= 0; i--) bits.push_back(PRE[i]);
        body.push_back(c[1]);
        body.push_back(c[0]);
        if (c != 2'b00)
            for (int i = plen - 1; i >= 0; i--) body.push_back(p[i]);
        crc = 8'h00;
        foreach (body[i]) begin
            fb  = crc[7] ^ body[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        foreach (body[i]) bits.push_back(body[i]);
        if (CRC_ON && c != 2'b00)
            for (int i = 7; i >= 0; i--) bits.push_back(crc[i] ^ (bad && i == 0));
        if (c == 2'b00 || bad) begin
            push_exp(1'b0);
        end else begin
            m_ord = m_ord + 2'd1;
            m_ctg = c;
            if (c == 2'b01) m_flag = p[7:0];
            if (c == 2'b10) m_scheme = p;
            push_exp(1'b1);
        end
        drive_bits(bits, gmax, idle_end);
    endtask

    initial begin
        bit          pb[$];
        int          n;
        logic [63:0] r64;
        logic [1:0]  rc;

        reset = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        repeat (100) tick();
        check("idle_ord", ord, 2'd0);
        check("idle_ctg", ctg, 2'd0);
        check("idle_rand", cur_rand, SEED);
        check("idle_flag", cur_flag, 8'd0);

        // Heartbeat
        send_frame(2'b11, 48'd0, 1'b0, 0, 1'b1);
        repeat (3) tick();
        check("hb_ctg", ctg, 2'b11);
        check("hb_ord", ord, 2'd1);
        check("hb_payload", {cur_flag, cur_scheme}, 56'd0);

        // Beacon then scheme with no gap between frames
        send_frame(2'b01, 48'h5A, 1'b0, 0, 1'b0);
        send_frame(2'b10, 48'h0410C4185210, 1'b0, 0, 1'b1);
        repeat (3) tick();
        check("seq_flag", cur_flag, 8'h5A);
        check("seq_scheme", cur_scheme, 48'h0410C4185210);
        check("seq_ctg", ctg, 2'b10);
        check("seq_ord", ord, 2'd3);

        // Corrupted CRC (reject only when the CRC is compiled in), then a good frame
        send_frame(2'b01, 48'hC3, 1'b1, 1, 1'b1);
        repeat (2) tick();
        send_frame(2'b01, 48'h3C, 1'b0, 1, 1'b1);
        repeat (3) tick();

        // Bad category
        send_frame(2'b00, 48'd0, 1'b0, 1, 1'b1);
        repeat (3) tick();

        // Timeout: preamble, ctg=10, 10 payload bits, then silence
        push_exp(1'b0);
        pb.delete();
        for (int i = 7; i >= 0; i--) pb.push_back(PRE[i]);
        pb.push_back(1'b1); pb.push_back(1'b0);
        for (int i = 0; i < 10; i++) pb.push_back(1'($urandom_range(1)));
        drive_bits(pb, 1, 1'b1);
        n = 0;
        while (n < TO + 50) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (frame_err) break;
        end
        check("timeout_latency", n, TO);
        #2;

        // Four heartbeats exercise the ord wrap
        for (int k = 0; k < 4; k++) send_frame(2'b11, 48'd0, 1'b0, 2, 1'b1);
        repeat (3) tick();
        check("wrap_ord", ord, m_ord);

        // Reset in the middle of a scheme payload
        pb.delete();
        for (int i = 7; i >= 0; i--) pb.push_back(PRE[i]);
        pb.push_back(1'b1); pb.push_back(1'b0);
        for (int i = 0; i < 20; i++) pb.push_back(1'($urandom_range(1)));
        drive_bits(pb, 0, 1'b1);
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        m_ord = 2'd0; m_ctg = 2'd0; m_flag = 8'd0; m_scheme = 48'd0;
        tick();
        check("post_reset_outputs", {ord, ctg, cur_flag, cur_scheme, cur_rand},
              {2'd0, 2'd0, 8'd0, 48'd0, SEED});
        send_frame(2'b10, 48'hFEDCBA987654, 1'b0, 1, 1'b1);
        repeat (3) tick();
        check("post_reset_accept", {ord, cur_scheme}, {2'd1, 48'hFEDCBA987654});

        // Randomised traffic
        for (int k = 0; k < 30; k++) begin
            r64 = {$urandom, $urandom};
            rc  = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) begin
                pb.delete();
                pb.push_back(1'b1); pb.push_back(1'b0); pb.push_back(1'b1); pb.push_back(1'b0);
                drive_bits(pb, 1, 1'b0);
            end
            send_frame(rc, r64[47:0], ($urandom_range(4) == 0), int'($urandom_range(2)),
                       (k == 29) || ($urandom_range(1) == 1));
            if (!bit_valid) repeat (int'($urandom_range(3))) tick();
        end
        bit_valid = 1'b0;
        repeat (20) tick();
        check("queue_drained", sbq.size(), 0);
        check("final_ord", ord, m_ord);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
